// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one single-port memory between two requesters
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int LATENCY = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ready,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    grant,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  localparam logic [3:0] CNT_LAST = 4'(LATENCY - 1);

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic          last_owner_q;
  logic          owner_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] m0_rdata_q;
  logic [DW-1:0] m1_rdata_q;
  logic          m0_ready_q;
  logic          m1_ready_q;
  logic          mem_we_q;

  logic          req_any_d;
  logic          win_d;

  // On a tie the port that did not win last time goes next.
  always_comb begin
    req_any_d = m0_req | m1_req;
    win_d     = (m0_req && m1_req) ? ~last_owner_q : m1_req;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      last_owner_q <= 1'b1;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
      m0_ready_q   <= 1'b0;
      m1_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
    end else begin
      m0_ready_q <= 1'b0;
      m1_ready_q <= 1'b0;
      mem_we_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_any_d) begin
            owner_q      <= win_d;
            last_owner_q <= win_d;
            we_q         <= win_d ? m1_we : m0_we;
            addr_q       <= win_d ? m1_addr : m0_addr;
            wdata_q      <= win_d ? m1_wdata : m0_wdata;
            mem_we_q     <= win_d ? m1_we : m0_we;
            cnt_q        <= 4'd0;
            state_q      <= ACCESS;
          end
        end
        ACCESS: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == CNT_LAST) begin
            state_q <= DONE;
            if (owner_q) begin
              m1_ready_q <= 1'b1;
              if (!we_q) m1_rdata_q <= mem_rdata;
            end else begin
              m0_ready_q <= 1'b1;
              if (!we_q) m0_rdata_q <= mem_rdata;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign m0_ready  = m0_ready_q;
  assign m1_ready  = m1_ready_q;
  assign mem_en    = (state_q == ACCESS);
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != IDLE);
  assign grant     = (state_q == IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter at LATENCY 1 and 3
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n     [2];
  logic        m0_req    [2];
  logic        m0_we     [2];
  logic [31:0] m0_addr   [2];
  logic [31:0] m0_wdata  [2];
  logic [31:0] m0_rdata  [2];
  logic        m0_ready  [2];
  logic        m1_req    [2];
  logic        m1_we     [2];
  logic [31:0] m1_addr   [2];
  logic [31:0] m1_wdata  [2];
  logic [31:0] m1_rdata  [2];
  logic        m1_ready  [2];
  logic        mem_en    [2];
  logic        mem_we    [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic [1:0]  grant     [2];
  logic        busy      [2];
  logic        pl_we     [2];
  logic [7:0]  pl_addr   [2];
  logic [31:0] pl_data   [2];

  int n_tests = 0;
  int n_fail  = 0;
  int ready_cnt [2];
  int we_cnt    [2];

  typedef struct {
    int          dut;
    int          port;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  // Instance 0 runs at LATENCY=1, instance 1 at LATENCY=3, each with its own memory.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [31:0] mem [256];

    mem_port_arbiter #(.AW(32), .DW(32), .LATENCY(g == 0 ? 1 : 3)) u_dut (
      .clk(clk), .reset(rst_n[g]),
      .m0_req(m0_req[g]), .m0_we(m0_we[g]), .m0_addr(m0_addr[g]), .m0_wdata(m0_wdata[g]),
      .m0_rdata(m0_rdata[g]), .m0_ready(m0_ready[g]),
      .m1_req(m1_req[g]), .m1_we(m1_we[g]), .m1_addr(m1_addr[g]), .m1_wdata(m1_wdata[g]),
      .m1_rdata(m1_rdata[g]), .m1_ready(m1_ready[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g]), .grant(grant[g]), .busy(busy[g])
    );

    assign mem_rdata[g] = mem_en[g] ? mem[mem_addr[g][7:0]] : 32'h0;

    always @(posedge clk) begin
      if (pl_we[g]) mem[pl_addr[g]] <= pl_data[g];
      else if (mem_en[g] && mem_we[g]) mem[mem_addr[g][7:0]] <= mem_wdata[g];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic ready_of(input int d, input int p);
    return (p == 0) ? m0_ready[d] : m1_ready[d];
  endfunction

  function automatic logic [31:0] rdata_of(input int d, input int p);
    return (p == 0) ? m0_rdata[d] : m1_rdata[d];
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_we[d]) we_cnt[d]++;
      for (int p = 0; p < 2; p++) begin
        if (ready_of(d, p)) begin
          exp_t e;
          ready_cnt[d]++;
          if (exp_q.size() == 0) begin
            check("unexpected_ready", 64'(d * 2 + p), 64'hFFFF);
          end else begin
            e = exp_q.pop_front();
            check("sb_dut", 64'(d), 64'(e.dut));
            check("sb_port", 64'(p), 64'(e.port));
            check("sb_rdata", 64'(rdata_of(d, p)), 64'(e.data));
            check("sb_grant", 64'(grant[d]), (p == 0) ? 64'd1 : 64'd2);
          end
        end
      end
    end
  end

  task automatic push_exp(input int d, input int p, input logic [31:0] v);
    exp_t e;
    e.dut = d; e.port = p; e.data = v;
    exp_q.push_back(e);
  endtask

  task automatic preload(input int d, input logic [7:0] a, input logic [31:0] v);
    pl_we[d] = 1'b1; pl_addr[d] = a; pl_data[d] = v;
    @(negedge clk);
    pl_we[d] = 1'b0;
  endtask

  task automatic set_req(input int d, input int p, input logic r, input logic we,
                         input logic [31:0] a, input logic [31:0] wd);
    if (p == 0) begin
      m0_req[d] = r; m0_we[d] = we; m0_addr[d] = a; m0_wdata[d] = wd;
    end else begin
      m1_req[d] = r; m1_we[d] = we; m1_addr[d] = a; m1_wdata[d] = wd;
    end
  endtask

  task automatic check_zero(input int d, input string tag);
    check({tag, "_rdata"}, {m0_rdata[d], m1_rdata[d]}, 64'h0);
    check({tag, "_bus"}, {mem_addr[d], mem_wdata[d]}, 64'h0);
    check({tag, "_ctl"}, 64'({m0_ready[d], m1_ready[d], mem_en[d], mem_we[d], grant[d], busy[d]}), 64'h0);
  endtask

  // Cycle 0 is the cycle the request is raised; returns the cycle ready was seen in.
  task automatic txn(input int d, input int p, input logic we, input logic [31:0] a,
                     input logic [31:0] wd, output int lat, output int en_cyc, output int busy_cyc);
    lat = 0; en_cyc = 0; busy_cyc = 0;
    set_req(d, p, 1'b1, we, a, wd);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (mem_en[d]) en_cyc++;
      if (busy[d]) busy_cyc++;
      if (ready_of(d, p)) begin
        lat = c;
        break;
      end
    end
    set_req(d, p, 1'b0, 1'b0, 32'h0, 32'h0);
    if (lat == 0) check("txn_timeout", 64'd0, 64'd1);
    @(negedge clk);
  endtask

  int lat, en_cyc, busy_cyc, w0, r0, k;
  int rc [4];
  logic [7:0] seq;

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; pl_we[d] = 1'b0; pl_addr[d] = 8'h0; pl_data[d] = 32'h0;
      ready_cnt[d] = 0; we_cnt[d] = 0;
      set_req(d, 0, 1'b0, 1'b0, 32'h0, 32'h0);
      set_req(d, 1, 1'b0, 1'b0, 32'h0, 32'h0);
    end
    repeat (3) @(negedge clk);
    check_zero(0, "reset0");
    check_zero(1, "reset1");
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;

    preload(0, 8'h10, 32'hDEADBEEF);
    push_exp(0, 0, 32'hDEADBEEF);
    txn(0, 0, 1'b0, 32'h10, 32'h0, lat, en_cyc, busy_cyc);
    check("t1_latency", 64'(lat), 64'd2);
    check("t1_en_cycles", 64'(en_cyc), 64'd1);

    w0 = we_cnt[0];
    push_exp(0, 1, 32'h0);
    txn(0, 1, 1'b1, 32'h0, 32'h00500093, lat, en_cyc, busy_cyc);
    push_exp(0, 0, 32'h00500093);
    txn(0, 0, 1'b0, 32'h0, 32'h0, lat, en_cyc, busy_cyc);
    check("t2_we_pulses", 64'(we_cnt[0] - w0), 64'd1);
    check("t2_m1_rdata", 64'(m1_rdata[0]), 64'h0);

    rst_n[0] = 1'b0;
    @(negedge clk);
    rst_n[0] = 1'b1;
    preload(0, 8'h30, 32'h11111111);
    preload(0, 8'h31, 32'h22222222);
    for (int i = 0; i < 2; i++) begin
      push_exp(0, 0, 32'h11111111);
      push_exp(0, 1, 32'h22222222);
    end
    set_req(0, 0, 1'b1, 1'b0, 32'h30, 32'h0);
    set_req(0, 1, 1'b1, 1'b0, 32'h31, 32'h0);
    k = 0; seq = 8'h0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (m0_ready[0] || m1_ready[0]) begin
        seq = {seq[5:0], grant[0]};
        rc[k] = c;
        k++;
        if (k == 4) break;
      end
    end
    set_req(0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(0, 1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("t3_count", 64'(k), 64'd4);
    check("t3_grant_seq", 64'(seq), 64'b01100110);
    check("t3_first_ready", 64'(rc[0]), 64'd2);
    check("t3_spacing", 64'(rc[3] - rc[0]), 64'd9);

    preload(1, 8'h40, 32'hCAFEF00D);
    w0 = we_cnt[1];
    push_exp(1, 1, 32'hCAFEF00D);
    txn(1, 1, 1'b0, 32'h40, 32'h0, lat, en_cyc, busy_cyc);
    check("t4_latency", 64'(lat), 64'd4);
    check("t4_en_cycles", 64'(en_cyc), 64'd3);
    check("t4_busy_cycles", 64'(busy_cyc), 64'd4);
    check("t4_no_we", 64'(we_cnt[1] - w0), 64'd0);

    r0 = ready_cnt[1];
    set_req(1, 0, 1'b1, 1'b0, 32'h40, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("t5_in_access", 64'(mem_en[1]), 64'd1);
    rst_n[1] = 1'b0;
    set_req(1, 0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check_zero(1, "t5_abort");
    rst_n[1] = 1'b1;
    repeat (6) @(negedge clk);
    check("t5_no_ready", 64'(ready_cnt[1] - r0), 64'd0);
    preload(1, 8'h41, 32'h5A5A5A5A);
    push_exp(1, 0, 32'h5A5A5A5A);
    txn(1, 0, 1'b0, 32'h41, 32'h0, lat, en_cyc, busy_cyc);
    check("t5_after_latency", 64'(lat), 64'd4);

    preload(1, 8'h10, 32'h12345678);
    preload(1, 8'h20, 32'h87654321);
    push_exp(1, 0, 32'h12345678);
    set_req(1, 0, 1'b1, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    check("t6_addr_c1", 64'(mem_addr[1]), 64'h10);
    m0_addr[1] = 32'h20;
    for (int c = 2; c <= 3; c++) begin
      @(negedge clk);
      check("t6_addr_hold", 64'({mem_en[1], mem_addr[1]}), {31'h0, 1'b1, 32'h10});
    end
    @(negedge clk);
    check("t6_ready", 64'(m0_ready[1]), 64'd1);
    set_req(1, 0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory between two requesters.
- Port 0 is the multicycle core's memory interface (fetch and load/store). Port 1 is the program loader / debug port.
- Serialises accesses through a small FSM, holds the memory control signals for a fixed access latency, and returns a one-cycle ready handshake with read data to the winning requester.
- Round-robin arbitration guarantees neither port starves.

Parameters:
AW, 32, address width in bits (word address driven straight to memory)
DW, 32, data width in bits
LATENCY, 1, memory access cycles per transaction (legal range 1..15)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset
m0_req  input  1  port 0 request, held until m0_ready
m0_we  input  1  port 0 write enable (1 = write, 0 = read)
m0_addr  input  AW  port 0 address
m0_wdata  input  DW  port 0 write data
m0_rdata  output  DW  port 0 read data, valid when m0_ready=1
m0_ready  output  1  port 0 transaction complete, one-cycle pulse
m1_req  input  1  port 1 request
m1_we  input  1  port 1 write enable
m1_addr  input  AW  port 1 address
m1_wdata  input  DW  port 1 write data
m1_rdata  output  DW  port 1 read data
m1_ready  output  1  port 1 complete pulse
mem_en  output  1  memory access enable
mem_we  output  1  memory write strobe
mem_addr  output  AW  memory address
mem_wdata  output  DW  memory write data
mem_rdata  input  DW  memory read data
grant  output  2  one-hot current owner; 00 when idle
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset: clk is the clock; reset is synchronous and active-low. While reset=0 on a rising edge:
  - state goes to IDLE and the latency counter clears to 0.
  - last_owner is set to 1, so port 0 wins the first tie.
  - All outputs are 0, including m0_rdata, m1_rdata, mem_addr and mem_wdata.
- Reset mid-transaction aborts immediately with no ready pulse. A write already strobed is not undone.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - Nothing requesting: stay in IDLE.
  - Exactly one req=1: grant that port.
  - Both req=1: grant the port that is not last_owner.
  - On grant: latch owner, we, addr and wdata into internal registers; set last_owner to the granted port; clear the counter; go to ACCESS.
- ACCESS (lasts exactly LATENCY cycles):
  - mem_en=1 throughout; mem_addr and mem_wdata come from the latched registers.
  - mem_we = latched_we, in the first ACCESS cycle only.
  - The counter increments each cycle. When the counter reaches LATENCY-1, mem_rdata is registered into the owner's rdata on that edge (reads only) and state goes to DONE.
- DONE (one cycle):
  - The owner's ready=1; grant still shows the owner; mem_en=0.
  - Always goes to IDLE next. Requests are not sampled in DONE.
- Latency: req high in IDLE cycle 0 → ready in cycle LATENCY+1. Back-to-back requests from one port cost LATENCY+2 cycles each.
- Inputs (we, addr, wdata) are sampled only at grant. Later changes have no effect on an in-flight transaction.
- Write transactions leave the owner's rdata unchanged. The non-owner's rdata is never touched. rdata holds its value until the next read completes for that port.
- Protocol violation (req dropped before ready): the transaction still completes and ready still pulses.
- Fairness: with both requesters continuously asserted, grants alternate 0,1,0,1,... No port waits more than one foreign transaction.
- grant: one-hot of the owner in ACCESS and DONE; 00 in IDLE.
- busy = (state != IDLE).

Test Plan:
- Single read: LATENCY=1, memory holds 0xDEADBEEF at 0x10; m0 reads 0x10 → mem_en high in cycle 1, m0_ready in cycle 2, m0_rdata=0xDEADBEEF, m1_ready never asserts.
- Loader write then core read: m1 writes 0x00500093 to 0x0; afterwards m0 reads 0x0 → exactly one mem_we pulse; m0_rdata=0x00500093; m1_rdata stays 0.
- Simultaneous requests: both req=1 out of reset → m0 granted first. Both kept asserted for 4 transactions → grant sequence 01,10,01,10 and no port misses its alternate turn.
- Latency 3: LATENCY=3, m1 read → mem_en high for 3 cycles, mem_we=0, m1_ready in cycle 4, busy high for cycles 1–4.
- Reset mid-access: LATENCY=3, reset=0 during the 2nd ACCESS cycle → next cycle all outputs 0, no ready pulse. A subsequent m0 request completes normally.
- Input change after grant: m0 changes addr 0x10→0x20 one cycle after grant → mem_addr stays 0x10 for the whole ACCESS phase.
